// File: rtl/exibe_sequencia_pkg.sv
// Shared game package: state codes (also used by the hex state display) and default timing.
// EXIBE_ACELERA_EN adds the per-round ON reduction defaults.
package exibe_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        ACESO   = 4'd3,
        APAGADO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam int ON_CYCLES_DEF  = 500;
    localparam int OFF_CYCLES_DEF = 250;
`ifdef EXIBE_ACELERA_EN
    localparam int STEP_CYCLES_DEF   = 25;
    localparam int MIN_ON_CYCLES_DEF = 100;
`endif

    // Bits needed to count 0..max(a,b)-1, never less than one.
    function automatic int largura_contador(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/exibe_sequencia_contador.sv
// Generic modulo-M counter: wraps to zero after reaching ultimo (M-1), which may change at run time.
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         zera,
    input  logic         conta,
    input  logic [W-1:0] ultimo,
    output logic         fim
);

    logic [W-1:0] valor;

    assign fim = (valor == ultimo);

    always_ff @(posedge clock) begin
        if (zera)
            valor <= '0;
        else if (conta)
            valor <= fim ? '0 : valor + 1'b1;
    end

endmodule

// File: rtl/exibe_sequencia.sv
// Memory-game playback: shows stored entries 0..rodada on the LEDs with ON/OFF timing.
// Optional EXIBE_ACELERA_EN shortens the ON time by STEP_CYCLES per round, floored at MIN_ON_CYCLES.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int ON_CYCLES  = ON_CYCLES_DEF,
    parameter int OFF_CYCLES = OFF_CYCLES_DEF
`ifdef EXIBE_ACELERA_EN
    ,
    parameter int STEP_CYCLES   = STEP_CYCLES_DEF,
    parameter int MIN_ON_CYCLES = MIN_ON_CYCLES_DEF
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

`ifdef EXIBE_ACELERA_EN
    localparam int CW = largura_contador((ON_CYCLES > MIN_ON_CYCLES) ? ON_CYCLES : MIN_ON_CYCLES,
                                         OFF_CYCLES);
`else
    localparam int CW = largura_contador(ON_CYCLES, OFF_CYCLES);
`endif
    localparam logic [CW-1:0] OFF_ULT = CW'(OFF_CYCLES - 1);

    estado_t           estado, prox;
    logic [ADDR_W-1:0] rodada_lat;
    logic [CW-1:0]     on_ult;
    logic [CW-1:0]     cont_ult;
    logic              cont_zera, cont_conta, cont_fim;
    logic              ultimo_end;

    assign ultimo_end = (mem_endereco == rodada_lat);
    assign ocupado    = (estado != INICIAL);
    assign pronto     = (estado == FIM);
    assign db_estado  = estado;

    // One counter serves both phases; it wraps to zero at the ACESO->APAGADO hand-over.
    assign cont_zera  = !reset || !(estado == ACESO || estado == APAGADO);
    assign cont_conta = (estado == ACESO) || (estado == APAGADO);
    assign cont_ult   = (estado == APAGADO) ? OFF_ULT : on_ult;

    contador_m #(.W(CW)) u_contador (
        .clock  (clock),
        .zera   (cont_zera),
        .conta  (cont_conta),
        .ultimo (cont_ult),
        .fim    (cont_fim)
    );

`ifdef EXIBE_ACELERA_EN
    // Wide unsigned math so a large round count clamps to the floor instead of underflowing.
    function automatic logic [CW-1:0] on_efetivo(input logic [ADDR_W-1:0] r);
        logic [63:0] reducao, bruto, efetivo;
        reducao = 64'(r) * 64'(STEP_CYCLES);
        bruto   = (reducao < 64'(ON_CYCLES)) ? 64'(ON_CYCLES) - reducao : 64'd0;
        efetivo = (bruto > 64'(MIN_ON_CYCLES)) ? bruto : 64'(MIN_ON_CYCLES);
        return CW'(efetivo - 64'd1);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset)
            on_ult <= CW'(ON_CYCLES - 1);
        else if (estado == INICIAL && iniciar)
            on_ult <= on_efetivo(rodada);
    end
`else
    assign on_ult = CW'(ON_CYCLES - 1);
`endif

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL: if (iniciar) prox = BUSCA;
            BUSCA:   prox = CARREGA;
            CARREGA: prox = ACESO;
            ACESO:   if (cont_fim) prox = APAGADO;
            APAGADO: if (cont_fim) prox = ultimo_end ? FIM : BUSCA;
            FIM:     prox = INICIAL;
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado       <= INICIAL;
            leds         <= '0;
            mem_endereco <= '0;
            rodada_lat   <= '0;
        end else begin
            estado <= prox;
            case (estado)
                INICIAL: begin
                    if (iniciar) begin
                        rodada_lat   <= rodada;
                        mem_endereco <= '0;
                    end
                end
                CARREGA: leds <= mem_dado;
                ACESO:   if (cont_fim) leds <= '0;
                APAGADO: begin
                    // Stop is checked first, so the address never steps past rodada.
                    if (cont_fim && !ultimo_end)
                        mem_endereco <= mem_endereco + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia (ON=4, OFF=2, STEP=1, MIN=2); honours EXIBE_ACELERA_EN.
module tb_exibe_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] rodada = '0;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    exibe_sequencia #(
        .ADDR_W(4), .DATA_W(4), .ON_CYCLES(4), .OFF_CYCLES(2)
`ifdef EXIBE_ACELERA_EN
        , .STEP_CYCLES(1), .MIN_ON_CYCLES(2)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .rodada       (rodada),
        .mem_dado     (mem_dado),
        .mem_endereco (mem_endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    logic [3:0] mem [0:15];
    always @(posedge clock) mem_dado <= mem[mem_endereco];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         fim;
        logic [3:0] val;
        logic [3:0] addr;
        int         len;
        int         inicio;
    } exp_t;

    exp_t sbq[$];
    int   erros  = 0;
    int   checks = 0;

    logic [3:0] tab_val [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic verifica(input string nome, input longint atual, input longint esperado);
        checks++;
        if (atual != esperado) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Hand-computed lit lengths per round.
    function automatic int on_len(input int r);
`ifdef EXIBE_ACELERA_EN
        case (r)
            0:       return 4;
            1:       return 3;
            default: return 2;
        endcase
`else
        return 4;
`endif
    endfunction

    // Monitor: closes a lit run when leds change, and checks each pronto pulse.
    logic       ativo = 1'b0;
    logic [3:0] run_val, run_addr;
    int         run_len, run_ini;

    task automatic fecha_entrada();
        exp_t e;
        if (sbq.size() == 0) begin
            verifica("unexpected_entry", 1, 0);
            return;
        end
        e = sbq.pop_front();
        verifica("entry_kind", e.fim, 0);
        verifica("entry_leds", run_val, e.val);
        verifica("entry_addr", run_addr, e.addr);
        verifica("entry_len", run_len, e.len);
        verifica("entry_start", run_ini, e.inicio);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            ativo = 1'b0;
            sbq.delete();
        end else begin
            if (ativo && leds != run_val) begin
                ativo = 1'b0;
                fecha_entrada();
            end
            if (leds != 4'd0) begin
                if (!ativo) begin
                    ativo    = 1'b1;
                    run_val  = leds;
                    run_addr = mem_endereco;
                    run_len  = 1;
                    run_ini  = cyc;
                end else begin
                    run_len++;
                end
                verifica("ocupado_lit", ocupado, 1);
            end
            if (pronto) begin
                if (sbq.size() == 0) begin
                    verifica("unexpected_pronto", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    verifica("pronto_kind", e.fim, 1);
                    verifica("pronto_cycle", cyc, e.inicio);
                    verifica("pronto_leds", leds, 0);
                end
            end
        end
    end

    // Start a playback and push its expected entries and completion.
    task automatic inicia(input int r, output int k);
        int on, per;
        @(posedge clock);
        #2;
        rodada  = 4'(r);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        k = cyc;
        #1;
        iniciar = 1'b0;
        on  = on_len(r);
        per = 2 + on + 2;
        for (int i = 0; i <= r; i++)
            sbq.push_back('{fim: 1'b0, val: tab_val[i], addr: 4'(i), len: on, inicio: k + 2 + i * per});
        sbq.push_back('{fim: 1'b1, val: 4'd0, addr: 4'd0, len: 0, inicio: k + (r + 1) * per});
    endtask

    task automatic espera_fim(input string nome);
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            if (sbq.size() == 0) break;
        end
        verifica(nome, sbq.size(), 0);
    endtask

    initial begin
        int k, per;
        for (int i = 0; i < 16; i++) mem[i] = 4'b1111;
        for (int i = 0; i < 4; i++)  mem[i] = tab_val[i];

        // Reset held low with iniciar high.
        reset   = 1'b0;
        iniciar = 1'b1;
        rodada  = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        verifica("rst_leds", leds, 0);
        verifica("rst_pronto", pronto, 0);
        verifica("rst_ocupado", ocupado, 0);
        verifica("rst_estado", db_estado, 0);
        verifica("rst_addr", mem_endereco, 0);
        @(posedge clock);
        #2;
        reset   = 1'b1;
        iniciar = 1'b0;

        inicia(0, k);
        espera_fim("done_r0");

        inicia(3, k);
        espera_fim("done_r3");

        // Restart request and rodada change while busy must be ignored.
        inicia(3, k);
        repeat (10) @(posedge clock);
        #2;
        iniciar = 1'b1;
        rodada  = 4'd1;
        @(posedge clock);
        #2;
        iniciar = 1'b0;
        espera_fim("done_r3_disturbed");

        // Reset while entry 2 is lit.
        inicia(3, k);
        per = 2 + on_len(3) + 2;
        repeat (2 + 2 * per) @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        verifica("midrst_leds", leds, 0);
        verifica("midrst_estado", db_estado, 0);
        verifica("midrst_ocupado", ocupado, 0);
        verifica("midrst_addr", mem_endereco, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        inicia(1, k);
        espera_fim("done_r1_after_reset");

        repeat (3) @(posedge clock);
        @(negedge clock);
        verifica("idle_estado", db_estado, 0);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
